// File: rtl/vc16_mem_pkg.sv
// rtl/vc16_mem_pkg.sv - shared types and constants for the vc16 memory sequencer
package vc16_mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam int BMASK_W         = 2;
  localparam int DEFAULT_TIMEOUT = 15;

endpackage

// File: rtl/mem_seq_if.sv
// rtl/mem_seq_if.sv - core, MMU and external bus signals of the memory sequencer
interface mem_seq_if
  import vc16_mem_pkg::*;
#(
  parameter int RV = 16,
  parameter int PA = RV
);
  logic               i_req;
  logic               i_ack;
  logic               i_fault;
  logic [RV-1:0]      i_data;
  logic               d_req;
  logic               d_write;
  logic [BMASK_W-1:0] d_bmask;
  logic [RV-1:0]      d_wdata;
  logic               d_ack;
  logic               d_fault;
  logic [RV-1:0]      d_rdata;
  logic               is_pc;
  logic               is_read;
  logic               is_write;
  logic [PA-1:1]      pcp;
  logic [PA-1:1]      addrp;
  logic               mmu_miss_fault;
  logic               mmu_prot_fault;
  logic               mmu_fault;
  logic               bus_req;
  logic               bus_write;
  logic [PA-1:1]      bus_addr;
  logic [BMASK_W-1:0] bus_bmask;
  logic [RV-1:0]      bus_wdata;
  logic               bus_ack;
  logic [RV-1:0]      bus_rdata;

  // the sequencer itself: serves the core, drives the MMU strobes and the bus
  modport slave (
    input  i_req, d_req, d_write, d_bmask, d_wdata, pcp, addrp,
    input  mmu_miss_fault, mmu_prot_fault, bus_ack, bus_rdata,
    output i_ack, i_fault, i_data, d_ack, d_fault, d_rdata,
    output is_pc, is_read, is_write, mmu_fault,
    output bus_req, bus_write, bus_addr, bus_bmask, bus_wdata
  );

  // the surroundings: core, MMU and memory model
  modport master (
    output i_req, d_req, d_write, d_bmask, d_wdata, pcp, addrp,
    output mmu_miss_fault, mmu_prot_fault, bus_ack, bus_rdata,
    input  i_ack, i_fault, i_data, d_ack, d_fault, d_rdata,
    input  is_pc, is_read, is_write, mmu_fault,
    input  bus_req, bus_write, bus_addr, bus_bmask, bus_wdata
  );
endinterface

// File: rtl/mem_seq_timeout.sv
// rtl/mem_seq_timeout.sv - bus wait counter, flags expiry on the last allowed BUS cycle
module mem_seq_timeout #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic active,
  output logic expired
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // counts BUS cycles; sits at zero outside BUS so every bus entry starts fresh
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (!active)
      cnt <= '0;
    else if (!expired)
      cnt <= cnt + 1'b1;
  end

  // the TIMEOUT-th BUS cycle without an ack is the last one
  assign expired = active && (cnt == CW'(TIMEOUT - 1));
endmodule

// File: rtl/mem_seq.sv
// rtl/mem_seq.sv - fetch/data memory sequencer behind the MMU; optional bus timeout via BUS_TIMEOUT_EN
module mem_seq
  import vc16_mem_pkg::*;
#(
  parameter int RV = 16,
  parameter int PA = RV
`ifdef BUS_TIMEOUT_EN
  , parameter int TIMEOUT = DEFAULT_TIMEOUT
`endif
) (
  input  logic       clk,
  input  logic       reset,
  mem_seq_if.slave   mif
);
  state_t             state, state_nx;
  logic               pri_i;
  logic               sel_i;
  logic [PA-1:1]      bus_addr_q;
  logic               bus_write_q;
  logic [BMASK_W-1:0] bus_bmask_q;
  logic [RV-1:0]      bus_wdata_q;
  logic [RV-1:0]      i_data_q;
  logic [RV-1:0]      d_rdata_q;
  logic               any_req;
  logic               pick_i;
  logic               mmu_flt;
  logic               in_bus;
  logic               timeout_hit;

  assign any_req = mif.i_req | mif.d_req;
  // data wins unless the fetch side is owed a turn
  assign pick_i  = mif.i_req & (pri_i | ~mif.d_req);
  assign mmu_flt = mif.mmu_miss_fault | mif.mmu_prot_fault;
  assign in_bus  = (state == ST_BUS);

`ifdef BUS_TIMEOUT_EN
  mem_seq_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .active  (in_bus),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // next state: MMU faults skip the bus, a bus ack beats a coincident timeout
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (any_req) state_nx = mmu_flt ? ST_FAULT : ST_BUS;
      ST_BUS:   if (mif.bus_ack) state_nx = ST_DONE;
                else if (timeout_hit) state_nx = ST_FAULT;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // outputs: MMU strobes only for the selected channel, all quiet during reset
  always_comb begin
    mif.is_pc     = 1'b0;
    mif.is_read   = 1'b0;
    mif.is_write  = 1'b0;
    mif.mmu_fault = 1'b0;
    mif.bus_req   = 1'b0;
    mif.i_ack     = 1'b0;
    mif.i_fault   = 1'b0;
    mif.d_ack     = 1'b0;
    mif.d_fault   = 1'b0;
    case (state)
      ST_IDLE: if (any_req && !reset) begin
        mif.is_pc     = pick_i;
        mif.is_read   = ~pick_i & ~mif.d_write;
        mif.is_write  = ~pick_i & mif.d_write;
        mif.mmu_fault = mmu_flt;
      end
      ST_BUS:  mif.bus_req = 1'b1;
      ST_DONE: begin
        mif.i_ack = sel_i;
        mif.d_ack = ~sel_i;
      end
      ST_FAULT: begin
        mif.i_ack   = sel_i;
        mif.d_ack   = ~sel_i;
        mif.i_fault = sel_i;
        mif.d_fault = ~sel_i;
      end
      default: ;
    endcase
  end

  // datapath: latch the bus request on leaving IDLE, capture result data for the ack
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_i       <= 1'b0;
      bus_addr_q  <= '0;
      bus_write_q <= 1'b0;
      bus_bmask_q <= '0;
      bus_wdata_q <= '0;
      i_data_q    <= '0;
      d_rdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: if (any_req) begin
          sel_i <= pick_i;
          if (mmu_flt) begin
            if (pick_i) i_data_q  <= '0;
            else        d_rdata_q <= '0;
          end else begin
            bus_addr_q  <= pick_i ? mif.pcp : mif.addrp;
            bus_write_q <= ~pick_i & mif.d_write;
            bus_bmask_q <= pick_i ? {BMASK_W{1'b1}} : mif.d_bmask;
            bus_wdata_q <= pick_i ? '0 : mif.d_wdata;
          end
        end
        ST_BUS: begin
          if (mif.bus_ack) begin
            if (sel_i) i_data_q  <= mif.bus_rdata;
            else       d_rdata_q <= bus_write_q ? '0 : mif.bus_rdata;
          end else if (timeout_hit) begin
            if (sel_i) i_data_q  <= '0;
            else       d_rdata_q <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // fairness: a data ack with a fetch waiting hands the next turn to fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pri_i <= 1'b0;
    else if (state == ST_DONE || state == ST_FAULT) begin
      if (sel_i)           pri_i <= 1'b0;
      else if (mif.i_req)  pri_i <= 1'b1;
    end
  end

  assign mif.bus_write = bus_write_q;
  assign mif.bus_addr  = bus_addr_q;
  assign mif.bus_bmask = bus_bmask_q;
  assign mif.bus_wdata = bus_wdata_q;
  assign mif.i_data    = i_data_q;
  assign mif.d_rdata   = d_rdata_q;
endmodule

// File: tb/tb_mem_seq.sv
// tb/tb_mem_seq.sv - directed self-checking bench for mem_seq
module tb_mem_seq;
  logic clk;
  logic reset;
  int   errors;
  int   checks;

  mem_seq_if #(.RV(16), .PA(16)) mif ();

  mem_seq dut (
    .clk   (clk),
    .reset (reset),
    .mif   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    mif.i_req = 1'b0;          mif.d_req = 1'b0;
    mif.d_write = 1'b0;        mif.d_bmask = 2'b00;
    mif.d_wdata = 16'h0;       mif.pcp = 15'h0;
    mif.addrp = 15'h0;         mif.mmu_miss_fault = 1'b0;
    mif.mmu_prot_fault = 1'b0; mif.bus_ack = 1'b0;
    mif.bus_rdata = 16'h0;

    // reset: outputs quiet even with requests pending
    tick();
    mif.i_req = 1'b1;
    mif.d_req = 1'b1;
    tick();
    chk("rst_is_pc",     32'(mif.is_pc),     32'h0);
    chk("rst_is_read",   32'(mif.is_read),   32'h0);
    chk("rst_mmu_fault", 32'(mif.mmu_fault), 32'h0);
    chk("rst_bus_req",   32'(mif.bus_req),   32'h0);
    chk("rst_i_ack",     32'(mif.i_ack),     32'h0);
    chk("rst_d_ack",     32'(mif.d_ack),     32'h0);
    chk("rst_bus_addr",  32'(mif.bus_addr),  32'h0);
    chk("rst_i_data",    32'(mif.i_data),    32'h0);
    mif.i_req = 1'b0;
    mif.d_req = 1'b0;
    reset = 1'b0;
    tick();

    // fetch, zero-wait bus
    mif.i_req = 1'b1;
    mif.pcp = 15'h1234;
    #1;
    chk("f_is_pc",     32'(mif.is_pc),     32'h1);
    chk("f_is_read",   32'(mif.is_read),   32'h0);
    chk("f_is_write",  32'(mif.is_write),  32'h0);
    chk("f_mmu_fault", 32'(mif.mmu_fault), 32'h0);
    chk("f_bus_req0",  32'(mif.bus_req),   32'h0);
    tick();
    chk("f_bus_req1",  32'(mif.bus_req),   32'h1);
    chk("f_bus_addr",  32'(mif.bus_addr),  32'h1234);
    chk("f_bus_bmask", 32'(mif.bus_bmask), 32'h3);
    chk("f_bus_write", 32'(mif.bus_write), 32'h0);
    mif.bus_ack = 1'b1;
    mif.bus_rdata = 16'hBEEF;
    tick();
    mif.bus_ack = 1'b0;
    chk("f_i_ack",     32'(mif.i_ack),     32'h1);
    chk("f_i_fault",   32'(mif.i_fault),   32'h0);
    chk("f_i_data",    32'(mif.i_data),    32'hBEEF);
    chk("f_bus_req2",  32'(mif.bus_req),   32'h0);
    chk("f_d_ack",     32'(mif.d_ack),     32'h0);
    mif.i_req = 1'b0;
    tick();
    chk("f_i_ack_off", 32'(mif.i_ack),     32'h0);
    chk("f_i_data_hold", 32'(mif.i_data),  32'hBEEF);

    // store with write-protect fault
    mif.d_req = 1'b1;
    mif.d_write = 1'b1;
    mif.d_bmask = 2'b01;
    mif.d_wdata = 16'h5555;
    mif.addrp = 15'h0010;
    mif.mmu_prot_fault = 1'b1;
    #1;
    chk("sp_is_write",  32'(mif.is_write),  32'h1);
    chk("sp_is_read",   32'(mif.is_read),   32'h0);
    chk("sp_is_pc",     32'(mif.is_pc),     32'h0);
    chk("sp_mmu_fault", 32'(mif.mmu_fault), 32'h1);
    tick();
    mif.mmu_prot_fault = 1'b0;
    chk("sp_d_ack",     32'(mif.d_ack),     32'h1);
    chk("sp_d_fault",   32'(mif.d_fault),   32'h1);
    chk("sp_d_rdata",   32'(mif.d_rdata),   32'h0);
    chk("sp_bus_req",   32'(mif.bus_req),   32'h0);
    chk("sp_i_ack",     32'(mif.i_ack),     32'h0);
    mif.d_req = 1'b0;
    mif.d_write = 1'b0;
    tick();
    chk("sp_d_ack_off", 32'(mif.d_ack),     32'h0);
    chk("sp_bus_req2",  32'(mif.bus_req),   32'h0);

    // simultaneous requests: data first, then fetch despite a new data request
    mif.i_req = 1'b1;
    mif.pcp = 15'h0100;
    mif.d_req = 1'b1;
    mif.addrp = 15'h0200;
    #1;
    chk("ar_is_read0", 32'(mif.is_read), 32'h1);
    chk("ar_is_pc0",   32'(mif.is_pc),   32'h0);
    tick();
    chk("ar_bus_addr0", 32'(mif.bus_addr), 32'h0200);
    mif.bus_ack = 1'b1;
    mif.bus_rdata = 16'h1111;
    tick();
    mif.bus_ack = 1'b0;
    chk("ar_d_ack",   32'(mif.d_ack),   32'h1);
    chk("ar_d_rdata", 32'(mif.d_rdata), 32'h1111);
    chk("ar_i_ack0",  32'(mif.i_ack),   32'h0);
    mif.addrp = 15'h0300;
    tick();
    chk("ar_is_pc1",   32'(mif.is_pc),   32'h1);
    chk("ar_is_read1", 32'(mif.is_read), 32'h0);
    tick();
    chk("ar_bus_addr1",  32'(mif.bus_addr),  32'h0100);
    chk("ar_bus_bmask1", 32'(mif.bus_bmask), 32'h3);
    mif.bus_ack = 1'b1;
    mif.bus_rdata = 16'h2222;
    tick();
    mif.bus_ack = 1'b0;
    chk("ar_i_ack",       32'(mif.i_ack),   32'h1);
    chk("ar_i_data",      32'(mif.i_data),  32'h2222);
    chk("ar_d_rdata_hold", 32'(mif.d_rdata), 32'h1111);
    mif.i_req = 1'b0;
    mif.d_req = 1'b0;
    tick();

    // priority returned to data; load with five BUS cycles
    mif.i_req = 1'b1;
    mif.pcp = 15'h0055;
    mif.d_req = 1'b1;
    mif.d_write = 1'b0;
    mif.d_bmask = 2'b10;
    mif.d_wdata = 16'hA5A5;
    mif.addrp = 15'h7FFF;
    #1;
    chk("ws_is_read", 32'(mif.is_read), 32'h1);
    chk("ws_is_pc",   32'(mif.is_pc),   32'h0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 2) mif.addrp = 15'h0001;
      chk("ws_bus_req",   32'(mif.bus_req),   32'h1);
      chk("ws_bus_addr",  32'(mif.bus_addr),  32'h7FFF);
      chk("ws_bus_bmask", 32'(mif.bus_bmask), 32'h2);
      chk("ws_bus_wdata", 32'(mif.bus_wdata), 32'hA5A5);
      chk("ws_bus_write", 32'(mif.bus_write), 32'h0);
      chk("ws_d_ack_wait", 32'(mif.d_ack),    32'h0);
      if (k == 5) begin
        mif.bus_ack = 1'b1;
        mif.bus_rdata = 16'hDEAD;
      end
    end
    tick();
    mif.bus_ack = 1'b0;
    chk("ws_d_ack",   32'(mif.d_ack),   32'h1);
    chk("ws_d_rdata", 32'(mif.d_rdata), 32'hDEAD);
    chk("ws_d_fault", 32'(mif.d_fault), 32'h0);
    chk("ws_bus_req", 32'(mif.bus_req), 32'h0);
    mif.d_req = 1'b0;
    tick();

    // pending fetch now served, and it misses in the MMU
    mif.mmu_miss_fault = 1'b1;
    #1;
    chk("fm_is_pc",     32'(mif.is_pc),     32'h1);
    chk("fm_mmu_fault", 32'(mif.mmu_fault), 32'h1);
    tick();
    mif.mmu_miss_fault = 1'b0;
    chk("fm_i_ack",   32'(mif.i_ack),   32'h1);
    chk("fm_i_fault", 32'(mif.i_fault), 32'h1);
    chk("fm_i_data",  32'(mif.i_data),  32'h0);
    chk("fm_bus_req", 32'(mif.bus_req), 32'h0);
    mif.i_req = 1'b0;
    tick();

    // reset while in BUS
    mif.i_req = 1'b1;
    mif.pcp = 15'h0042;
    tick();
    chk("rb_bus_req1", 32'(mif.bus_req), 32'h1);
    reset = 1'b1;
    #1;
    chk("rb_bus_req_async", 32'(mif.bus_req), 32'h0);
    tick();
    chk("rb_i_ack", 32'(mif.i_ack), 32'h0);
    tick();
    mif.i_req = 1'b0;
    reset = 1'b0;
    tick();
    chk("rb_bus_req_after", 32'(mif.bus_req), 32'h0);
    chk("rb_i_ack_after",   32'(mif.i_ack),   32'h0);
    chk("rb_d_rdata",       32'(mif.d_rdata), 32'h0);
    mif.i_req = 1'b1;
    mif.pcp = 15'h0077;
    #1;
    chk("rb_is_pc", 32'(mif.is_pc), 32'h1);
    tick();
    chk("rb_bus_addr", 32'(mif.bus_addr), 32'h0077);
    mif.bus_ack = 1'b1;
    mif.bus_rdata = 16'h0F0F;
    tick();
    mif.bus_ack = 1'b0;
    chk("rb_i_ack_new",  32'(mif.i_ack),  32'h1);
    chk("rb_i_data_new", 32'(mif.i_data), 32'h0F0F);
    mif.i_req = 1'b0;
    tick();

`ifdef BUS_TIMEOUT_EN
    // no bus ack: fifteen BUS cycles, then a faulted ack without mmu_fault
    mif.d_req = 1'b1;
    mif.d_write = 1'b0;
    mif.addrp = 15'h0123;
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk("to_bus_req",   32'(mif.bus_req),   32'h1);
      chk("to_mmu_fault", 32'(mif.mmu_fault), 32'h0);
    end
    tick();
    chk("to_bus_req_off", 32'(mif.bus_req),   32'h0);
    chk("to_d_ack",       32'(mif.d_ack),     32'h1);
    chk("to_d_fault",     32'(mif.d_fault),   32'h1);
    chk("to_mmu_fault2",  32'(mif.mmu_fault), 32'h0);
    mif.d_req = 1'b0;
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_seq.md
Name: mem_seq

Overview:
- Memory access sequencer sitting directly downstream of the MMU in the vc16 core.
- Arbitrates between the fetch and data request channels, and drives the MMU check strobes (is_pc/is_read/is_write).
- Samples the MMU's translated address and fault flags, and pulses mmu_fault so the MMU captures fault state.
- Otherwise runs one external bus transaction per request and returns the result to the core.

Parameters:
RV, 16, data/register width
PA, RV, physical address width; addresses are word addresses [PA-1:1]
TIMEOUT, 15, bus wait cycles before abort (only with BUS_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
i_req  in  1  fetch request; held until i_ack
i_ack  out  1  fetch complete, one-cycle pulse
i_fault  out  1  fetch faulted; valid with i_ack
i_data  out  RV  fetched word; valid with i_ack
d_req  in  1  data request; held until d_ack
d_write  in  1  1 = store, 0 = load
d_bmask  in  2  byte lane enables
d_wdata  in  RV  store data
d_ack  out  1  data complete, one-cycle pulse
d_fault  out  1  data access faulted; valid with d_ack
d_rdata  out  RV  load data; valid with d_ack
is_pc  out  1  MMU fetch check strobe
is_read  out  1  MMU load check strobe
is_write  out  1  MMU store check strobe
pcp  in  PA-1  translated fetch address [PA-1:1]
addrp  in  PA-1  translated data address [PA-1:1]
mmu_miss_fault  in  1  MMU miss, combinational from strobes
mmu_prot_fault  in  1  MMU write-protect, combinational from strobes
mmu_fault  out  1  tells MMU to latch fault info this cycle
bus_req  out  1  external bus request
bus_write  out  1  bus store
bus_addr  out  PA-1  bus word address
bus_bmask  out  2  bus byte enables
bus_wdata  out  RV  bus store data
bus_ack  in  1  bus transaction complete
bus_rdata  in  RV  bus load data, valid with bus_ack

Behaviour:
- While reset is high: state IDLE; all outputs 0; pri_i flag 0; bus registers 0.
- States: IDLE, BUS, DONE, FAULT.
- IDLE, channel select:
  - Data wins unless pri_i=1 and i_req=1.
  - Strobes are combinational for the selected channel only:
    - fetch: is_pc=1
    - load: is_read=1
    - store: is_write=1 (d_bmask ignored by MMU)
  - At most one strobe is high.
- IDLE, MMU fault: fault = mmu_miss_fault|mmu_prot_fault.
  - mmu_fault = selected & fault, in the same cycle, so the MMU captures its inputs.
  - Next state FAULT.
- IDLE, no fault:
  - Register bus_addr (pcp or addrp), bus_write, bus_bmask (2'b11 for fetch), bus_wdata.
  - Next state BUS.
- FAULT: pulse the selected x_ack and x_fault=1, x_data=0; then IDLE.
- BUS:
  - bus_req=1; bus_addr/bus_write/bus_bmask/bus_wdata held stable.
  - On bus_ack: capture bus_rdata, drop bus_req in the next cycle, go to DONE.
- DONE: pulse x_ack with x_fault=0 and captured data (0 for stores); then IDLE.
- Fairness: pri_i is set on d_ack whenever i_req is high, and cleared on i_ack.
- Latency:
  - Fault: x_ack at cycle 1 after the request cycle.
  - Zero-wait bus (bus_ack in first BUS cycle): x_ack at cycle 2.
  - Generally: x_ack = 1 + BUS cycles + 1.
- Core must not drop or change x_req before x_ack; behaviour is undefined if it does.
- A request arriving while the block is not IDLE waits.
- Reset mid-transaction: bus_req drops asynchronously and no ack is issued; the memory side must tolerate an abandoned request.
- i_data/d_rdata hold their last value between acks.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- Defined:
  - A counter clears on BUS entry and increments each BUS cycle without bus_ack.
  - When it reaches TIMEOUT: drop bus_req and go to FAULT, so the ack carries x_fault=1.
  - mmu_fault is not pulsed (not an MMU fault).
  - bus_ack and timeout in the same cycle: the ack wins.
- Undefined: no counter; BUS waits indefinitely.

Decomposition:
- Shared package vc16_mem_pkg:
  - state enum (IDLE/BUS/DONE/FAULT)
  - BMASK_W=2
  - default TIMEOUT
- Optional sub-module mem_seq_timeout (counter plus compare), instantiated only under BUS_TIMEOUT_EN.
- Arbitration stays inline.

Test Plan:
- Fetch, no fault: i_req=1, pcp=15'h1234, bus_ack on first BUS cycle with bus_rdata=16'hBEEF -> is_pc=1 cycle 0, bus_req/bus_addr=15'h1234 cycle 1, i_ack=1, i_data=16'hBEEF, i_fault=0 at cycle 2.
- Store prot fault: d_req=1, d_write=1, mmu_prot_fault=1 -> is_write=1 and mmu_fault=1 cycle 0, d_ack=1 and d_fault=1 cycle 1, bus_req never asserted.
- Simultaneous i_req and d_req, pri_i=0 -> data served first; pri_i=1 after d_ack; fetch served next, even with a new d_req pending.
- Wait states: bus_ack after 5 BUS cycles -> bus signals stable throughout, d_ack 1 cycle after bus_ack with d_rdata=bus_rdata.
- Reset asserted in BUS -> bus_req=0 immediately, no ack, IDLE after release.
- BUS_TIMEOUT_EN, TIMEOUT=15, no bus_ack -> bus_req drops after 15 cycles, x_ack with x_fault=1, mmu_fault stays 0.
